// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM capture path: sequencer states,
// filter flush length and the default PCM sample width.
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        WARMUP = 2'd2,
        RUN    = 2'd3
    } pdm_state_e;

    // Number of cycles the CIC is held in reset after a start.
    localparam int unsigned FLUSH_CYCLES  = 2;

    localparam int unsigned PCM_W_DEFAULT = 16;

endpackage

// File: rtl/pdm_sample_fifo.sv
// Synchronous PCM sample FIFO with registered occupancy and a sticky
// overflow flag. The head entry is presented combinationally (0 when empty).
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module pdm_sample_fifo
    import pdm_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = PCM_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    // Accept/drop decisions for this cycle's push and pop requests
    always_comb begin
        full    = (level == FULL_LVL);
        do_pop  = pop && (level != '0);
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
    end

    // Storage array write; the head slot is never overwritten while
    // still valid because a full-FIFO push requires a simultaneous pop
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    // Head presentation, forced to zero when empty
    always_comb begin
        head = (level == '0) ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: PDM clock / per-bit tick generation, CIC reset
// sequencing, warm-up sample discard and PCM sample buffering.
// Optional build macro PDM_AUTOSTOP_EN adds sample_limit/done for an
// automatic stop after a programmed number of RUN samples.
module pdm_capture_ctrl
    import pdm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PCM_W      = PCM_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [7:0]                    period,
    input  logic [3:0]                    warmup,
    input  logic [$clog2(FIFO_DEPTH):0]   thresh,
    input  logic [PCM_W-1:0]              pcm_in,
    input  logic                          pcm_in_valid,
    input  logic                          rd_en,
    input  logic                          ovf_clr,
    output logic                          pdm_clk_out,
    output logic                          pdm_tick,
    output logic                          filt_rst,
    output logic [PCM_W-1:0]              rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overflow,
    output logic                          irq
`ifdef PDM_AUTOSTOP_EN
    ,
    input  logic [15:0]                   sample_limit,
    output logic                          done
`endif
);

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    pdm_state_e  state;
    logic [7:0]  per_q;
    logic [7:0]  phase;
    logic [3:0]  wu_cnt;
    logic [1:0]  flush_cnt;
    logic        active;
    logic        fifo_push;
`ifdef PDM_AUTOSTOP_EN
    logic [15:0] smp_cnt;
`endif

    // Status decode shared by the clock generator and outputs
    always_comb begin
        active    = (state != IDLE);
        busy      = active;
        filt_rst  = (state == IDLE) || (state == FLUSH);
        fifo_push = (state == RUN) && pcm_in_valid;
    end

    // Sequencer: start acceptance, flush timing, warm-up discard, stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            per_q     <= '0;
            wu_cnt    <= '0;
            flush_cnt <= '0;
`ifdef PDM_AUTOSTOP_EN
            smp_cnt   <= '0;
            done      <= 1'b0;
`endif
        end else begin
`ifdef PDM_AUTOSTOP_EN
            done <= 1'b0;
`endif
            if (stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && (period >= 8'd2)) begin
                            state     <= FLUSH;
                            per_q     <= period;
                            wu_cnt    <= warmup;
                            flush_cnt <= '0;
`ifdef PDM_AUTOSTOP_EN
                            smp_cnt   <= '0;
`endif
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == FLUSH_LAST)
                            state <= (wu_cnt == '0) ? RUN : WARMUP;
                        else
                            flush_cnt <= flush_cnt + 2'd1;
                    end
                    WARMUP: begin
                        if (pcm_in_valid) begin
                            wu_cnt <= wu_cnt - 4'd1;
                            if (wu_cnt == 4'd1)
                                state <= RUN;
                        end
                    end
                    RUN: begin
`ifdef PDM_AUTOSTOP_EN
                        if (pcm_in_valid) begin
                            smp_cnt <= smp_cnt + 16'd1;
                            if ((sample_limit != '0) && (smp_cnt + 16'd1 == sample_limit)) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // PDM bit-clock phase counter, held at 0 while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase <= '0;
        else if (stop || !active || (phase == per_q - 8'd1))
            phase <= '0;
        else
            phase <= phase + 8'd1;
    end

    // PDM clock is high for the first half of each period; the tick
    // marks phase 0, which is the cycle the clock rises
    always_comb begin
        pdm_clk_out = active && (phase < (per_q >> 1));
        pdm_tick    = active && (phase == '0);
    end

    pdm_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PCM_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pcm_in),
        .pop       (rd_en),
        .ovf_clr   (ovf_clr),
        .head      (rd_data),
        .level     (level),
        .overflow  (overflow)
    );

    // Level-threshold interrupt; threshold 0 disables it
    always_comb begin
        irq = (thresh != '0) && (level >= thresh);
    end

endmodule
